// File: rtl/operand_fetcher.sv
// operand_fetcher: fetches a 6502 opcode and its operand bytes, decodes the addressing
// mode, resolves the effective address and hands one instruction per handshake downstream.
module operand_fetcher #(
    parameter int                    REG_WIDTH     = 8,
    parameter int                    ADDR_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] START_PC      = 16'h0600,
    parameter int                    CROSS_PENALTY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_ready,
    input  logic [REG_WIDTH-1:0]  x_in,
    input  logic [REG_WIDTH-1:0]  y_in,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [REG_WIDTH-1:0]  dec_opcode,
    output logic [3:0]            dec_mode,
    output logic [REG_WIDTH-1:0]  dec_imm,
    output logic [ADDR_WIDTH-1:0] dec_ea,
    output logic                  dec_page_cross,
    output logic [ADDR_WIDTH-1:0] dec_pc_next
);

    localparam logic [3:0] M_IMP = 4'd0, M_ACC = 4'd1, M_IMM = 4'd2, M_ZPG = 4'd3,
                           M_ZPG_X = 4'd4, M_ZPG_Y = 4'd5, M_ABS = 4'd6, M_ABS_X = 4'd7,
                           M_ABS_Y = 4'd8, M_IND = 4'd9, M_X_IND = 4'd10, M_IND_Y = 4'd11,
                           M_REL = 4'd12;

    typedef enum logic [2:0] {S_IDLE, S_OPC, S_OP1, S_OP2, S_PTRL, S_PTRH, S_FIX, S_OUT} state_t;

    function automatic logic [3:0] decode_mode(input logic [REG_WIDTH-1:0] op);
        logic [2:0] aaa;
        logic [2:0] bbb;
        aaa = op[7:5];
        bbb = op[4:2];
        decode_mode = M_IMP;
        case (op[1:0])
            2'b01: begin
                case (bbb)
                    3'd0: decode_mode = M_X_IND;
                    3'd1: decode_mode = M_ZPG;
                    3'd2: decode_mode = M_IMM;
                    3'd3: decode_mode = M_ABS;
                    3'd4: decode_mode = M_IND_Y;
                    3'd5: decode_mode = M_ZPG_X;
                    3'd6: decode_mode = M_ABS_Y;
                    default: decode_mode = M_ABS_X;
                endcase
            end
            2'b10: begin
                case (bbb)
                    3'd0: decode_mode = M_IMM;
                    3'd1: decode_mode = M_ZPG;
                    3'd2: decode_mode = M_ACC;
                    3'd3: decode_mode = M_ABS;
                    3'd5: decode_mode = (aaa == 3'd4 || aaa == 3'd5) ? M_ZPG_Y : M_ZPG_X;
                    3'd7: decode_mode = (aaa == 3'd5) ? M_ABS_Y : M_ABS_X;
                    default: decode_mode = M_IMP;
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'd0: decode_mode = (aaa >= 3'd5) ? M_IMM :
                                        (op[7:0] == 8'h20) ? M_ABS : M_IMP;
                    3'd1: decode_mode = M_ZPG;
                    3'd3: decode_mode = (op[7:0] == 8'h6C) ? M_IND : M_ABS;
                    3'd4: decode_mode = M_REL;
                    3'd5: decode_mode = M_ZPG_X;
                    3'd7: decode_mode = M_ABS_X;
                    default: decode_mode = M_IMP;
                endcase
            end
            default: decode_mode = M_IMP;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, ptr_q, ptr_d;
    logic [REG_WIDTH-1:0]  opcode_q, opcode_d, op1_q, op1_d, op2_q, op2_d, lo_q, lo_d;
    logic [3:0]            mode_q, mode_d;
    logic [REG_WIDTH-1:0]  dec_opcode_q, dec_opcode_d, dec_imm_q, dec_imm_d;
    logic [3:0]            dec_mode_q, dec_mode_d;
    logic [ADDR_WIDTH-1:0] dec_ea_q, dec_ea_d, dec_pc_next_q, dec_pc_next_d;
    logic                  dec_page_cross_q, dec_page_cross_d;

    logic [3:0]            mode_rd, mode_cur;
    logic [REG_WIDTH-1:0]  opc_cur, op1_cur, op2_cur, idx;
    logic [REG_WIDTH:0]    lo_sum;
    logic [ADDR_WIDTH-1:0] pc_inc, pc_next_cur, abs_base, ind_base, fin_ea;
    logic                  fin_cross, fin;

    // Values as they will be once the read completing this cycle is captured.
    always_comb begin
        mode_rd     = decode_mode(mem_rdata);
        mode_cur    = (state_q == S_OPC) ? mode_rd : mode_q;
        opc_cur     = (state_q == S_OPC) ? mem_rdata : opcode_q;
        op1_cur     = (state_q == S_OP1) ? mem_rdata : op1_q;
        op2_cur     = (state_q == S_OP2) ? mem_rdata : op2_q;
        pc_inc      = pc_q + ADDR_WIDTH'(1);
        pc_next_cur = (state_q == S_PTRH) ? pc_q : pc_inc;
        abs_base    = ADDR_WIDTH'({op2_cur, op1_cur});
        ind_base    = ADDR_WIDTH'({mem_rdata, lo_q});
        idx         = (mode_cur == M_ZPG_Y || mode_cur == M_ABS_Y || mode_cur == M_IND_Y) ? y_in : x_in;
        lo_sum      = (mode_cur == M_IND_Y) ? {1'b0, lo_q} + {1'b0, idx} : {1'b0, op1_cur} + {1'b0, idx};
        fin_ea      = '0;
        fin_cross   = 1'b0;
        case (mode_cur)
            M_ZPG:            fin_ea = ADDR_WIDTH'(op1_cur);
            M_ZPG_X, M_ZPG_Y: fin_ea = ADDR_WIDTH'(lo_sum[REG_WIDTH-1:0]);
            M_ABS:            fin_ea = abs_base;
            M_ABS_X, M_ABS_Y: begin
                fin_ea    = abs_base + ADDR_WIDTH'(idx);
                fin_cross = lo_sum[REG_WIDTH];
            end
            M_IND, M_X_IND:   fin_ea = ind_base;
            M_IND_Y: begin
                fin_ea    = ind_base + ADDR_WIDTH'(idx);
                fin_cross = lo_sum[REG_WIDTH];
            end
            M_REL: begin
                fin_ea    = pc_next_cur + ADDR_WIDTH'(signed'(op1_cur));
                fin_cross = fin_ea[ADDR_WIDTH-1:REG_WIDTH] != pc_next_cur[ADDR_WIDTH-1:REG_WIDTH];
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_addr = pc_q;
        mem_rd   = 1'b0;
        case (state_q)
            S_OPC, S_OP1, S_OP2: mem_rd = 1'b1;
            S_PTRL: begin
                mem_rd   = 1'b1;
                mem_addr = ptr_q;
            end
            // High pointer byte never carries into the page (zero-page wrap, JMP bug).
            S_PTRH: begin
                mem_rd   = 1'b1;
                mem_addr = {ptr_q[ADDR_WIDTH-1:REG_WIDTH], ptr_q[REG_WIDTH-1:0] + REG_WIDTH'(1)};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        ptr_d            = ptr_q;
        opcode_d         = opcode_q;
        mode_d           = mode_q;
        op1_d            = op1_q;
        op2_d            = op2_q;
        lo_d             = lo_q;
        dec_opcode_d     = dec_opcode_q;
        dec_mode_d       = dec_mode_q;
        dec_imm_d        = dec_imm_q;
        dec_ea_d         = dec_ea_q;
        dec_page_cross_d = dec_page_cross_q;
        dec_pc_next_d    = dec_pc_next_q;
        fin              = 1'b0;
        if (pc_load) begin
            state_d = S_OPC;
            pc_d    = pc_load_val;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_OPC;
                S_OPC: if (mem_ready) begin
                    opcode_d = mem_rdata;
                    mode_d   = mode_rd;
                    pc_d     = pc_inc;
                    if (mode_rd == M_IMP || mode_rd == M_ACC) fin = 1'b1;
                    else state_d = S_OP1;
                end
                S_OP1: if (mem_ready) begin
                    op1_d = mem_rdata;
                    pc_d  = pc_inc;
                    if (mode_q == M_ABS || mode_q == M_ABS_X || mode_q == M_ABS_Y || mode_q == M_IND) begin
                        state_d = S_OP2;
                    end else if (mode_q == M_X_IND) begin
                        ptr_d   = ADDR_WIDTH'(lo_sum[REG_WIDTH-1:0]);
                        state_d = S_PTRL;
                    end else if (mode_q == M_IND_Y) begin
                        ptr_d   = ADDR_WIDTH'(mem_rdata);
                        state_d = S_PTRL;
                    end else begin
                        fin = 1'b1;
                    end
                end
                S_OP2: if (mem_ready) begin
                    op2_d = mem_rdata;
                    pc_d  = pc_inc;
                    if (mode_q == M_IND) begin
                        ptr_d   = ADDR_WIDTH'({mem_rdata, op1_q});
                        state_d = S_PTRL;
                    end else begin
                        fin = 1'b1;
                    end
                end
                S_PTRL: if (mem_ready) begin
                    lo_d    = mem_rdata;
                    state_d = S_PTRH;
                end
                S_PTRH: if (mem_ready) fin = 1'b1;
                S_FIX:  state_d = S_OUT;
                S_OUT:  if (dec_ready) state_d = S_OPC;
                default: state_d = S_IDLE;
            endcase
            if (fin) begin
                state_d          = (CROSS_PENALTY != 0 && fin_cross) ? S_FIX : S_OUT;
                dec_opcode_d     = opc_cur;
                dec_mode_d       = mode_cur;
                dec_imm_d        = (mode_cur == M_IMM) ? op1_cur : '0;
                dec_ea_d         = fin_ea;
                dec_page_cross_d = fin_cross;
                dec_pc_next_d    = pc_next_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            pc_q             <= START_PC;
            ptr_q            <= '0;
            opcode_q         <= '0;
            mode_q           <= M_IMP;
            op1_q            <= '0;
            op2_q            <= '0;
            lo_q             <= '0;
            dec_opcode_q     <= '0;
            dec_mode_q       <= M_IMP;
            dec_imm_q        <= '0;
            dec_ea_q         <= '0;
            dec_page_cross_q <= 1'b0;
            dec_pc_next_q    <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            ptr_q            <= ptr_d;
            opcode_q         <= opcode_d;
            mode_q           <= mode_d;
            op1_q            <= op1_d;
            op2_q            <= op2_d;
            lo_q             <= lo_d;
            dec_opcode_q     <= dec_opcode_d;
            dec_mode_q       <= dec_mode_d;
            dec_imm_q        <= dec_imm_d;
            dec_ea_q         <= dec_ea_d;
            dec_page_cross_q <= dec_page_cross_d;
            dec_pc_next_q    <= dec_pc_next_d;
        end
    end

    assign dec_valid      = (state_q == S_OUT);
    assign dec_opcode     = dec_opcode_q;
    assign dec_mode       = dec_mode_q;
    assign dec_imm        = dec_imm_q;
    assign dec_ea         = dec_ea_q;
    assign dec_page_cross = dec_page_cross_q;
    assign dec_pc_next    = dec_pc_next_q;

endmodule
